// File: rtl/ritc_train_pkg.sv
// ritc_train_pkg: shared FSM states, lane geometry and default training nibble for the train monitor
package ritc_train_pkg;
  localparam int LANES = 12;
  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] TRAIN_PATTERN_DEF = 4'b1010;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/ritc_train_lane_cnt.sv
// ritc_train_lane_cnt: one-lane registered pattern compare plus error counter and sticky flag
// RITC_TRAIN_MON_SATURATE_EN makes the counter hold at all-ones instead of wrapping
module ritc_train_lane_cnt
  import ritc_train_pkg::*;
#(
  parameter int              CNT_WIDTH     = 16,
  parameter logic [NIB_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF
) (
  input  logic                 SYSCLK,
  input  logic                 rst_n_i,
  input  logic [NIB_W-1:0]     nib_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 err_o
);
  logic                 mis_q, err_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef RITC_TRAIN_MON_SATURATE_EN
  assign cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
`else
  assign cnt_d = cnt_q + 1'b1;
`endif
  always_ff @(posedge SYSCLK) begin
    if (!rst_n_i) begin
      mis_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mis_q <= nib_i != TRAIN_PATTERN;
      if (clr_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (en_i && mis_q) begin
        cnt_q <= cnt_d;
        err_q <= 1'b1;
      end
    end
  end
  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/ritc_train_monitor.sv
// ritc_train_monitor: windowed per-lane training-pattern error monitor on one selected RITC channel
// Optional RITC_TRAIN_MON_SATURATE_EN build makes the lane counters saturate instead of wrap
module ritc_train_monitor
  import ritc_train_pkg::*;
#(
  parameter int               NUM_CH        = 6,
  parameter int               CNT_WIDTH     = 16,
  parameter int               WIN_WIDTH     = 24,
  parameter logic [NIB_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF
) (
  input  logic                   SYSCLK,
  input  logic                   rst_n_i,
  input  logic [NUM_CH*48-1:0]   ch_dat_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [2:0]             ch_sel_i,
  input  logic [WIN_WIDTH-1:0]   win_len_i,
  input  logic [3:0]             lane_sel_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  output logic [LANES-1:0]       err_lanes_o
);
  logic [1:0]           state_q, state_d;
  logic                 flush_q, flush_d, clr;
  logic [WIN_WIDTH-1:0] win_q, win_d;
  logic [2:0]           ch_sel_q, ch_sel_d;
  logic [47:0]          sel_d, dat_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;
  logic [CNT_WIDTH-1:0] cnt [16];
  always_comb begin
    sel_d = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_sel_q == 3'(c)) sel_d = ch_dat_i[48*c +: 48];
  end
  // abort beats everything, including a coincident start
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    win_d    = win_q;
    ch_sel_d = ch_sel_q;
    clr      = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else if (start_i && (state_q == IDLE || state_q == DONE)) begin
      state_d  = FLUSH;
      flush_d  = 1'b0;
      win_d    = win_len_i;
      ch_sel_d = ch_sel_i;
      clr      = 1'b1;
    end else if (state_q == FLUSH) begin
      flush_d = 1'b1;
      state_d = !flush_q ? FLUSH : (win_q == '0 ? DONE : COUNT);
    end else if (state_q == COUNT) begin
      win_d   = win_q - 1'b1;
      state_d = win_q == WIN_WIDTH'(1) ? DONE : COUNT;
    end
  end
  always_ff @(posedge SYSCLK) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      flush_q   <= 1'b0;
      win_q     <= '0;
      ch_sel_q  <= '0;
      dat_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      win_q     <= win_d;
      ch_sel_q  <= ch_sel_d;
      dat_q     <= sel_d;
      err_cnt_q <= cnt[lane_sel_i];
    end
  end
  for (genvar l = 0; l < 16; l++) begin : g_lane
    if (l < LANES) begin : g_cnt
      ritc_train_lane_cnt #(
        .CNT_WIDTH    (CNT_WIDTH),
        .TRAIN_PATTERN(TRAIN_PATTERN)
      ) u_lane (
        .SYSCLK (SYSCLK),
        .rst_n_i(rst_n_i),
        .nib_i  (dat_q[NIB_W*l +: NIB_W]),
        .clr_i  (clr),
        .en_i   (state_q == COUNT),
        .cnt_o  (cnt[l]),
        .err_o  (err_lanes_o[l])
      );
    end else begin : g_zero
      assign cnt[l] = '0;
    end
  end
  assign busy_o    = state_q == FLUSH || state_q == COUNT;
  assign done_o    = state_q == DONE;
  assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_ritc_train_monitor.sv
// tb_ritc_train_monitor: scoreboard bench for ritc_train_monitor, with a CNT_WIDTH=4 twin for wrap/saturation
module tb_ritc_train_monitor;
  import ritc_train_pkg::*;
  localparam int NUM_CH = 6;
  logic SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;
  logic                 rst_n_i, start_i, abort_i;
  logic [NUM_CH*48-1:0] ch_dat_i;
  logic [2:0]           ch_sel_i;
  logic [23:0]          win_len_i;
  logic [3:0]           lane_sel_i;
  logic                 busy_o, done_o, busy4, done4;
  logic [15:0]          err_cnt_o;
  logic [3:0]           err_cnt4;
  logic [11:0]          err_lanes_o, err_lanes4;
  typedef struct packed {
    logic [11:0]       lanes;
    logic [11:0][15:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t last_e;
  int   exp_cnt [12];
  int   checks = 0;
  int   errors = 0;

  ritc_train_monitor u_dut (
    .SYSCLK(SYSCLK), .rst_n_i(rst_n_i), .ch_dat_i(ch_dat_i), .start_i(start_i),
    .abort_i(abort_i), .ch_sel_i(ch_sel_i), .win_len_i(win_len_i), .lane_sel_i(lane_sel_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .err_lanes_o(err_lanes_o)
  );
  ritc_train_monitor #(.CNT_WIDTH(4)) u_dut4 (
    .SYSCLK(SYSCLK), .rst_n_i(rst_n_i), .ch_dat_i(ch_dat_i), .start_i(start_i),
    .abort_i(abort_i), .ch_sel_i(ch_sel_i), .win_len_i(win_len_i), .lane_sel_i(lane_sel_i),
    .busy_o(busy4), .done_o(done4), .err_cnt_o(err_cnt4), .err_lanes_o(err_lanes4)
  );

  function automatic int cnt4(input int c);
`ifdef RITC_TRAIN_MON_SATURATE_EN
    return c > 15 ? 15 : c;
`else
    return c % 16;
`endif
  endfunction

  function automatic logic [47:0] gen_word(input int mode, input int i);
    logic [47:0] w;
    w = {12{4'b1010}};
    if (mode == 1 && (i * 7) % 100 < 37) w[23:20] = 4'b0101;
    if (mode == 2) w = 48'({$urandom(), $urandom()});
    return w;
  endfunction

  task automatic tick;
    @(posedge SYSCLK);
    #1;
  endtask

  // drives one word onto every channel and, if counted, scores it against the training nibble
  task automatic drive(input logic [2:0] ch, input int mode, input int i, input bit count);
    logic [47:0] w, sel;
    for (int c = 0; c < NUM_CH; c++) ch_dat_i[48*c +: 48] = 48'({$urandom(), $urandom()});
    w = gen_word(mode, i);
    if (ch < 3'd6) ch_dat_i[48*int'(ch) +: 48] = w;
    sel = ch < 3'd6 ? w : 48'd0;
    if (count)
      for (int b = 0; b < 12; b++) if (sel[4*b +: 4] != 4'b1010) exp_cnt[b]++;
  endtask

  task automatic run(input logic [2:0] ch, input int win, input int mode, input int abort_k,
                     input bit flush_start);
    int   busy_n, done_k;
    exp_t e;
    busy_n = 0;
    done_k = -1;
    for (int b = 0; b < 12; b++) exp_cnt[b] = 0;
    abort_i   = 1'b0;
    start_i   = 1'b1;
    ch_sel_i  = ch;
    win_len_i = 24'(win);
    drive(ch, mode, 0, 1'b0);
    tick;
    for (int k = 0; k < win + 10; k++) begin
      drive(ch, mode, k, k < win && (abort_k < 0 || k <= abort_k - 2));
      start_i   = flush_start && k == 0;
      win_len_i = start_i ? 24'd5 : 24'(win);
      abort_i   = k == abort_k;
      if (done_o === 1'b1) begin
        done_k = k;
        break;
      end
      if (busy_o === 1'b1) busy_n++;
      if (k == abort_k) begin
        tick;
        break;
      end
      tick;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    if (abort_k >= 0) begin
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy_o, done_o);
      end
      checks++;
      if (busy_n !== abort_k + 1) begin
        errors++;
        $display("FAIL abort_busy_len: got %0d, required %0d", busy_n, abort_k + 1);
      end
    end else begin
      checks++;
      if (done_k !== win + 2) begin
        errors++;
        $display("FAIL done_latency win=%0d: done seen at %0d (-1 = timeout), required %0d", win, done_k, win + 2);
      end
      checks++;
      if (busy_n !== win + 2) begin
        errors++;
        $display("FAIL busy_len win=%0d: got %0d, required %0d", win, busy_n, win + 2);
      end
    end
    for (int b = 0; b < 12; b++) begin
      e.cnt[b]   = 16'(exp_cnt[b]);
      e.lanes[b] = exp_cnt[b] != 0;
    end
    sb.push_back(e);
  endtask

  task automatic check_results(input string name);
    exp_t e;
    logic [15:0] want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: empty, required one entry", name);
      return;
    end
    e = sb.pop_front();
    last_e = e;
    checks++;
    if (err_lanes_o !== e.lanes || err_lanes4 !== e.lanes) begin
      errors++;
      $display("FAIL %s err_lanes: got %h/%h, required %h", name, err_lanes_o, err_lanes4, e.lanes);
    end
    for (int l = 0; l < 16; l++) begin
      lane_sel_i = 4'(l);
      tick;
      want = l < 12 ? e.cnt[l] : 16'd0;
      checks++;
      if (err_cnt_o !== want || err_cnt4 !== 4'(cnt4(int'(want)))) begin
        errors++;
        $display("FAIL %s err_cnt lane %0d: got %0d/%0d, required %0d/%0d", name, l, err_cnt_o,
                 err_cnt4, want, cnt4(int'(want)));
      end
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    tick;
    tick;
    checks++;
    if ({busy_o, done_o, err_cnt_o, err_lanes_o, err_cnt4, err_lanes4} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cnt=%0d lanes=%h, required all 0", busy_o, done_o, err_cnt_o, err_lanes_o);
    end
    rst_n_i = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    run(3'd2, 100, 0, -1, 1'b0);
    check_results("ideal");
    run(3'd0, 100, 1, -1, 1'b0);
    check_results("single_lane");
    run(3'd3, 40, 2, -1, 1'b0);
    check_results("random");
  endtask

  task automatic test_invalid_channel;
    run(3'd7, 10, 0, -1, 1'b0);
    check_results("invalid_ch7");
    run(3'd6, 20, 0, -1, 1'b0);
    check_results("saturate_wrap");
  endtask

  task automatic test_abort;
    run(3'd7, 100, 0, 51, 1'b1);
    check_results("abort_at_50");
    abort_i   = 1'b1;
    start_i   = 1'b1;
    ch_sel_i  = 3'd0;
    win_len_i = 24'd10;
    tick;
    abort_i = 1'b0;
    start_i = 1'b0;
    tick;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: busy=%b done=%b, required 0 0", busy_o, done_o);
    end
    sb.push_back(last_e);
    check_results("start_with_abort_frozen");
  endtask

  task automatic test_zero_window;
    run(3'd1, 0, 2, -1, 1'b0);
    check_results("zero_window");
  endtask

  task automatic test_reset_mid;
    start_i   = 1'b1;
    ch_sel_i  = 3'd7;
    win_len_i = 24'd100;
    lane_sel_i = 4'd3;
    tick;
    start_i = 1'b0;
    for (int k = 0; k < 30; k++) tick;
    checks++;
    if (busy_o !== 1'b1 || err_lanes_o !== 12'hFFF) begin
      errors++;
      $display("FAIL mid_count: busy=%b lanes=%h, required 1 fff", busy_o, err_lanes_o);
    end
    rst_n_i = 1'b0;
    tick;
    rst_n_i = 1'b1;
    checks++;
    if ({busy_o, done_o, err_cnt_o, err_lanes_o, err_cnt4, err_lanes4} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b cnt=%0d lanes=%h, required all 0", busy_o, done_o, err_cnt_o, err_lanes_o);
    end
    tick;
  endtask

  initial begin
    rst_n_i    = 1'b0;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    ch_dat_i   = '0;
    ch_sel_i   = '0;
    win_len_i  = '0;
    lane_sel_i = '0;
    test_reset;
    test_back_to_back;
    test_invalid_channel;
    test_abort;
    test_zero_window;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
